// File: rtl/dtcore32_lsu.sv
// dtcore32 MEM-stage load/store unit: drives a req/gnt/rvalid data-memory
// transaction, raises the pipeline stall, and returns extended load data.
module dtcore32_lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        MEM_valid_i,
    input  logic        MEM_rd_en_i,
    input  logic        MEM_wr_en_i,
    input  logic [31:0] MEM_addr_i,
    input  logic [31:0] MEM_wdata_i,
    input  logic [1:0]  MEM_size_i,
    input  logic        MEM_unsigned_i,
    output logic [31:0] MEM_rdata_o,
    output logic        MEM_stall_o,
    output logic        MEM_misaligned_o,
    output logic        MEM_access_fault_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i
);

    // state | meaning
    // IDLE  | no transaction; aligned access starts one
    // REQ   | dmem_req_o held until gnt (or flush aborts)
    // RESP  | load granted, waiting for rvalid
    // DONE  | result presented, stall released for one cycle
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;

    lsu_state_e  state_q, state_d;
    logic        drain_q, drain_d;
    logic        access;
    logic        misaligned;
    logic        start;
    logic        capture;
    logic        stall;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        unsigned_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign access = MEM_valid_i & (MEM_rd_en_i | MEM_wr_en_i);

    always_comb begin
        be_d       = 4'b1111;
        wdata_d    = MEM_wdata_i;
        misaligned = 1'b0;
        case (MEM_size_i)
            2'b00: begin
                be_d    = 4'b0001 << MEM_addr_i[1:0];
                wdata_d = {4{MEM_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d       = MEM_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{MEM_wdata_i[15:0]}};
                misaligned = MEM_addr_i[0];
            end
            default: begin
                misaligned = |MEM_addr_i[1:0];
            end
        endcase
    end

    // Lane selection uses the address/size latched at request time.
    always_comb begin
        byte_sel = 8'h00;
        case (lane_q)
            2'd0: byte_sel = dmem_rdata_i[7:0];
            2'd1: byte_sel = dmem_rdata_i[15:8];
            2'd2: byte_sel = dmem_rdata_i[23:16];
            default: byte_sel = dmem_rdata_i[31:24];
        endcase
        half_sel = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        start   = 1'b0;
        capture = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                drain_d = 1'b0;
                if (access && !misaligned) begin
                    start   = 1'b1;
                    stall   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_gnt_i) begin
                    // a granted request cannot be withdrawn; a flushed load still drains
                    if (dmem_we_o) begin
                        state_d = MEM_valid_i ? DONE : IDLE;
                    end else begin
                        state_d = RESP;
                        drain_d = ~MEM_valid_i;
                    end
                end else if (!MEM_valid_i) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (!MEM_valid_i) begin
                    drain_d = 1'b1;
                end
                if (dmem_rvalid_i) begin
                    drain_d = 1'b0;
                    if (drain_q || !MEM_valid_i) begin
                        state_d = IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gated by reset so every output reads 0 while rst_ni is low.
    assign MEM_stall_o      = stall & rst_ni;
    assign MEM_misaligned_o = access & misaligned & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q            <= IDLE;
            drain_q            <= 1'b0;
            dmem_req_o         <= 1'b0;
            dmem_we_o          <= 1'b0;
            dmem_addr_o        <= 32'h0;
            dmem_be_o          <= 4'h0;
            dmem_wdata_o       <= 32'h0;
            size_q             <= 2'b00;
            lane_q             <= 2'b00;
            unsigned_q         <= 1'b0;
            MEM_rdata_o        <= 32'h0;
            MEM_access_fault_o <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (start) begin
                dmem_req_o         <= 1'b1;
                dmem_we_o          <= ~MEM_rd_en_i;
                dmem_addr_o        <= {MEM_addr_i[31:2], 2'b00};
                dmem_be_o          <= be_d;
                dmem_wdata_o       <= wdata_d;
                size_q             <= MEM_size_i;
                lane_q             <= MEM_addr_i[1:0];
                unsigned_q         <= MEM_unsigned_i;
                MEM_access_fault_o <= 1'b0;
            end else if (state_q == REQ && (dmem_gnt_i || !MEM_valid_i)) begin
                dmem_req_o <= 1'b0;
            end
            if (capture) begin
                MEM_rdata_o        <= load_ext;
                MEM_access_fault_o <= dmem_err_i;
            end
        end
    end

endmodule
